// File: rtl/lcd_op_sequencer_if.sv
// lcd_op_sequencer_if
//   Bundles the request, handshake and display-bus signals between the
//   datapath, the sequencer and the LCD display stage.
//   power/start/opcode_in/addr_in/data_in : request side (datapath -> sequencer)
//   done_off/done_show                    : display stage status flags
//   operation/opcode/addr/data_addr       : latched instruction to display stage
//   busy/pending/overflow/timeout         : sequencer status
//   slave modport = sequencer, master modport = environment driving it.
interface lcd_op_sequencer_if;
  logic        power;
  logic        start;
  logic [3:0]  opcode_in;
  logic [3:0]  addr_in;
  logic [15:0] data_in;
  logic        done_off;
  logic        done_show;
  logic [1:0]  operation;
  logic [3:0]  opcode;
  logic [3:0]  addr;
  logic [15:0] data_addr;
  logic        busy;
  logic        pending;
  logic        overflow;
  logic        timeout;

  modport master (
    output power, start, opcode_in, addr_in, data_in, done_off, done_show,
    input  operation, opcode, addr, data_addr, busy, pending, overflow, timeout
  );

  modport slave (
    input  power, start, opcode_in, addr_in, data_in, done_off, done_show,
    output operation, opcode, addr, data_addr, busy, pending, overflow, timeout
  );
endinterface

// File: rtl/lcd_op_sequencer.sv
// lcd_op_sequencer
//   Latches executed instructions and walks the LCD display stage through
//   DISPLAY_OFF -> UPDATE -> SHOW, holding one queued request while a refresh
//   is in progress. Flags overflow (request dropped) and SHOW timeout.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : lcd_op_sequencer_if.slave (request, handshake and status signals)
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   OFF     | display forced off; waits for power
//   UPDATE  | operation=UPDATE held for UPDATE_HOLD cycles
//   SHOW    | operation=SHOW, waits for done_show (after guard) or timeout
//   IDLE    | screen shown, waiting for the next request
module lcd_op_sequencer #(
  parameter int UPDATE_HOLD  = 100000,
  parameter int SHOW_TIMEOUT = 5000000,
  parameter int SHOW_GUARD   = 2
) (
  input logic              clk,
  input logic              rst_n,
  lcd_op_sequencer_if.slave bus
);

  localparam int CNT_MAX = (UPDATE_HOLD > SHOW_TIMEOUT) ? UPDATE_HOLD : SHOW_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_UPDATE = 2'd1,
    ST_SHOW   = 2'd2,
    ST_IDLE   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       operation_q, operation_d;
  logic             busy_q, busy_d;
  logic [3:0]       opcode_q, opcode_d;
  logic [3:0]       addr_q, addr_d;
  logic [15:0]      data_q, data_d;
  logic [3:0]       q_opcode_q, q_opcode_d;
  logic [3:0]       q_addr_q, q_addr_d;
  logic [15:0]      q_data_q, q_data_d;
  logic             pending_q, pending_d;
  logic             overflow_q, overflow_d;
  logic             timeout_q, timeout_d;
  logic             pop;
  logic             take_direct;
  logic             push;

  // done_off is informational; the sequencer never waits on it.
  logic unused_done_off;
  assign unused_done_off = bus.done_off;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_OFF;
      cnt_q       <= '0;
      operation_q <= 2'd0;
      busy_q      <= 1'b0;
      opcode_q    <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      q_opcode_q  <= '0;
      q_addr_q    <= '0;
      q_data_q    <= '0;
      pending_q   <= 1'b0;
      overflow_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      operation_q <= operation_d;
      busy_q      <= busy_d;
      opcode_q    <= opcode_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      q_opcode_q  <= q_opcode_d;
      q_addr_q    <= q_addr_d;
      q_data_q    <= q_data_d;
      pending_q   <= pending_d;
      overflow_q  <= overflow_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    opcode_d    = opcode_q;
    addr_d      = addr_q;
    data_d      = data_q;
    q_opcode_d  = q_opcode_q;
    q_addr_d    = q_addr_q;
    q_data_d    = q_data_q;
    pending_d   = pending_q;
    overflow_d  = overflow_q;
    timeout_d   = timeout_q;
    operation_d = 2'd0;
    busy_d      = 1'b0;
    pop         = 1'b0;
    take_direct = 1'b0;
    push        = 1'b0;

    if (!bus.power) begin
      // Power loss aborts any refresh; the queue survives so the request is
      // shown once power returns.
      state_d = ST_OFF;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          pop     = pending_q;
          state_d = ST_UPDATE;
          cnt_d   = '0;
        end
        ST_UPDATE: begin
          if (cnt_q == CNT_W'(UPDATE_HOLD - 1)) begin
            state_d = ST_SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_SHOW: begin
          // A done_show left over from the previous screen is ignored until
          // the display stage has had SHOW_GUARD cycles to drop it.
          if (bus.done_show && (cnt_q >= CNT_W'(SHOW_GUARD))) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_W'(SHOW_TIMEOUT - 1)) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_IDLE: begin
          cnt_d = '0;
          if (pending_q) begin
            pop     = 1'b1;
            state_d = ST_UPDATE;
          end else if (bus.start) begin
            take_direct = 1'b1;
            state_d     = ST_UPDATE;
          end
        end
        default: begin
          state_d = ST_OFF;
          cnt_d   = '0;
        end
      endcase
    end

    if (pop) begin
      opcode_d = q_opcode_q;
      addr_d   = q_addr_q;
      data_d   = q_data_q;
    end else if (take_direct) begin
      opcode_d = bus.opcode_in;
      addr_d   = bus.addr_in;
      data_d   = bus.data_in;
    end

    // Any start not consumed directly goes to the one-deep queue. When the
    // queue is being popped in the same cycle the slot is free, so no overflow.
    push = bus.start && !take_direct;
    if (push) begin
      q_opcode_d = bus.opcode_in;
      q_addr_d   = bus.addr_in;
      q_data_d   = bus.data_in;
      pending_d  = 1'b1;
      if (pending_q && !pop) begin
        overflow_d = 1'b1;
      end
    end else if (pop) begin
      pending_d = 1'b0;
    end

    case (state_d)
      ST_OFF:    operation_d = 2'd0;
      ST_UPDATE: operation_d = 2'd1;
      default:   operation_d = 2'd2;
    endcase
    busy_d = (state_d == ST_UPDATE) || (state_d == ST_SHOW);
  end

  assign bus.operation = operation_q;
  assign bus.opcode    = opcode_q;
  assign bus.addr      = addr_q;
  assign bus.data_addr = data_q;
  assign bus.busy      = busy_q;
  assign bus.pending   = pending_q;
  assign bus.overflow  = overflow_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_lcd_op_sequencer.sv
module tb_lcd_op_sequencer;
  localparam int UH = 8;
  localparam int STO = 64;
  localparam int SG = 2;

  localparam int P_OFF  = 0;
  localparam int P_UPD  = 1;
  localparam int P_SHOW = 2;
  localparam int P_IDLE = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lcd_op_sequencer_if bus ();

  lcd_op_sequencer #(
    .UPDATE_HOLD (UH),
    .SHOW_TIMEOUT(STO),
    .SHOW_GUARD  (SG)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  ad;
    logic [15:0] da;
  } req_t;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: phase, remaining UPDATE cycles, cycles spent in SHOW,
  // a queue of at most one request and the request currently on the display.
  req_t q[$];
  req_t shown;
  int   m_phase;
  int   upd_left;
  int   show_age;
  bit   m_ovf;
  bit   m_tmo;

  function automatic void m_reset();
    q.delete();
    shown    = '0;
    m_phase  = P_OFF;
    upd_left = 0;
    show_age = 0;
    m_ovf    = 1'b0;
    m_tmo    = 1'b0;
  endfunction

  function automatic void m_enqueue(req_t r);
    if (q.size() != 0) begin
      m_ovf = 1'b1;
      q.delete();
    end
    q.push_back(r);
  endfunction

  function automatic void m_start_refresh();
    m_phase  = P_UPD;
    upd_left = UH;
  endfunction

  function automatic void m_clock(bit pw, bit st, req_t r, bit dsh);
    if (!pw) begin
      if (st) m_enqueue(r);
      m_phase = P_OFF;
      return;
    end
    case (m_phase)
      P_OFF: begin
        if (q.size() != 0) shown = q.pop_front();
        if (st) m_enqueue(r);
        m_start_refresh();
      end
      P_UPD: begin
        if (st) m_enqueue(r);
        upd_left--;
        if (upd_left == 0) begin
          m_phase  = P_SHOW;
          show_age = 0;
        end
      end
      P_SHOW: begin
        if (st) m_enqueue(r);
        show_age++;
        if (dsh && show_age > SG) m_phase = P_IDLE;
        else if (show_age == STO) begin
          m_tmo   = 1'b1;
          m_phase = P_IDLE;
        end
      end
      default: begin
        if (q.size() != 0) begin
          shown = q.pop_front();
          if (st) m_enqueue(r);
          m_start_refresh();
        end else if (st) begin
          shown = r;
          m_start_refresh();
        end
      end
    endcase
  endfunction

  task automatic check_outputs(string tag);
    logic [1:0] eop;
    logic       ebusy;
    logic       epend;
    eop   = (m_phase == P_OFF) ? 2'd0 : (m_phase == P_UPD) ? 2'd1 : 2'd2;
    ebusy = (m_phase == P_UPD) || (m_phase == P_SHOW);
    epend = (q.size() != 0);
    vectors++;
    assert (bus.operation === eop) else begin
      miscompares++;
      $error("FAIL %s operation: got %0d expected %0d", tag, bus.operation, eop);
    end
    assert (bus.opcode === shown.op) else begin
      miscompares++;
      $error("FAIL %s opcode: got %0h expected %0h", tag, bus.opcode, shown.op);
    end
    assert (bus.addr === shown.ad) else begin
      miscompares++;
      $error("FAIL %s addr: got %0h expected %0h", tag, bus.addr, shown.ad);
    end
    assert (bus.data_addr === shown.da) else begin
      miscompares++;
      $error("FAIL %s data_addr: got %0h expected %0h", tag, bus.data_addr, shown.da);
    end
    assert (bus.busy === ebusy) else begin
      miscompares++;
      $error("FAIL %s busy: got %0b expected %0b", tag, bus.busy, ebusy);
    end
    assert (bus.pending === epend) else begin
      miscompares++;
      $error("FAIL %s pending: got %0b expected %0b", tag, bus.pending, epend);
    end
    assert (bus.overflow === m_ovf) else begin
      miscompares++;
      $error("FAIL %s overflow: got %0b expected %0b", tag, bus.overflow, m_ovf);
    end
    assert (bus.timeout === m_tmo) else begin
      miscompares++;
      $error("FAIL %s timeout: got %0b expected %0b", tag, bus.timeout, m_tmo);
    end
  endtask

  // Spec-level constant expectations, independent of the model.
  task automatic expect_eq(string tag, logic [15:0] got, logic [15:0] exp);
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(string tag);
    req_t r;
    bit   pw;
    bit   st;
    bit   dsh;
    r   = {bus.opcode_in, bus.addr_in, bus.data_in};
    pw  = bus.power;
    st  = bus.start;
    dsh = bus.done_show;
    @(posedge clk);
    m_clock(pw, st, r, dsh);
    #1;
    check_outputs(tag);
    bus.start = 1'b0;
  endtask

  task automatic issue(logic [3:0] op, logic [3:0] ad, logic [15:0] da);
    bus.start     = 1'b1;
    bus.opcode_in = op;
    bus.addr_in   = ad;
    bus.data_in   = da;
  endtask

  initial begin
    bus.power     = 1'b0;
    bus.start     = 1'b0;
    bus.opcode_in = '0;
    bus.addr_in   = '0;
    bus.data_in   = '0;
    bus.done_off  = 1'b0;
    bus.done_show = 1'b0;
    rst_n         = 1'b1;
    m_reset();
    #2 rst_n = 1'b0;
    #10;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 1: power-on, UPDATE for 8 cycles, then SHOW with zero data
    bus.power = 1'b1;
    step("t1_on");
    expect_eq("t1_op_upd_first", 16'(bus.operation), 16'd1);
    repeat (UH - 1) step("t1_upd");
    expect_eq("t1_op_upd_last", 16'(bus.operation), 16'd1);
    expect_eq("t1_data_zero", bus.data_addr, 16'h0000);
    // 4: done_show already high on SHOW entry
    bus.done_show = 1'b1;
    step("t1_to_show");
    expect_eq("t1_op_show", 16'(bus.operation), 16'd2);
    step("t4_guard1");
    expect_eq("t4_busy_guard1", 16'(bus.busy), 16'd1);
    step("t4_guard2");
    expect_eq("t4_busy_guard2", 16'(bus.busy), 16'd1);
    step("t4_accept");
    expect_eq("t4_busy_accept", 16'(bus.busy), 16'd0);
    bus.done_show = 1'b0;

    // 2: direct start from IDLE
    issue(4'd1, 4'd3, 16'h8005);
    step("t2_start");
    expect_eq("t2_opcode", 16'(bus.opcode), 16'd1);
    expect_eq("t2_addr", 16'(bus.addr), 16'd3);
    expect_eq("t2_data", bus.data_addr, 16'h8005);
    repeat (UH) step("t2_upd");
    repeat (4) step("t2_show");
    expect_eq("t2_busy_show", 16'(bus.busy), 16'd1);
    bus.done_show = 1'b1;
    step("t2_done");
    expect_eq("t2_busy_idle", 16'(bus.busy), 16'd0);
    bus.done_show = 1'b0;

    // 3: queueing and overflow
    issue(4'd9, 4'd1, 16'h1234);
    step("t3_start");
    step("t3_upd");
    issue(4'd5, 4'd2, 16'h0055);
    step("t3_q_upd");
    expect_eq("t3_pending", 16'(bus.pending), 16'd1);
    expect_eq("t3_no_ovf", 16'(bus.overflow), 16'd0);
    repeat (UH - 2) step("t3_upd2");
    issue(4'd2, 4'd4, 16'h7fff);
    step("t3_q_show");
    expect_eq("t3_ovf", 16'(bus.overflow), 16'd1);
    bus.done_show = 1'b1;
    repeat (2) step("t3_done");
    bus.done_show = 1'b0;
    step("t3_pop");
    expect_eq("t3_opcode_next", 16'(bus.opcode), 16'd2);
    expect_eq("t3_pending_clr", 16'(bus.pending), 16'd0);

    // 5: SHOW timeout
    repeat (UH) step("t5_upd");
    repeat (STO - 1) step("t5_wait");
    expect_eq("t5_no_tmo_yet", 16'(bus.timeout), 16'd0);
    step("t5_expire");
    expect_eq("t5_tmo", 16'(bus.timeout), 16'd1);
    expect_eq("t5_op", 16'(bus.operation), 16'd2);
    expect_eq("t5_idle", 16'(bus.busy), 16'd0);

    // 6: power loss mid-UPDATE, start in OFF, restart, async reset mid-SHOW
    issue(4'd3, 4'd9, 16'hffff);
    step("t6_start");
    repeat (3) step("t6_upd");
    bus.power = 1'b0;
    step("t6_off");
    expect_eq("t6_op_off", 16'(bus.operation), 16'd0);
    issue(4'd7, 4'd6, 16'h0042);
    step("t6_q_off");
    step("t6_off2");
    bus.power = 1'b1;
    step("t6_on");
    expect_eq("t6_opcode_q", 16'(bus.opcode), 16'd7);
    repeat (UH - 1) step("t6_upd2");
    expect_eq("t6_op_upd_last", 16'(bus.operation), 16'd1);
    step("t6_show");
    expect_eq("t6_op_show", 16'(bus.operation), 16'd2);
    step("t6_show2");
    #3 rst_n = 1'b0;
    #1;
    expect_eq("t6_rst_op", 16'(bus.operation), 16'd0);
    expect_eq("t6_rst_data", bus.data_addr, 16'h0000);
    expect_eq("t6_rst_flags",
              16'({bus.busy, bus.pending, bus.overflow, bus.timeout}), 16'd0);
    m_reset();
    check_outputs("t6_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the model
    bus.power = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      bus.power = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 5) == 0) begin
        issue(4'($urandom_range(0, 7)), 4'($urandom), 16'($urandom));
      end
      if (i < 750) bus.done_show = ($urandom_range(0, 3) == 0);
      else         bus.done_show = ($urandom_range(0, 45) == 0);
      bus.done_off = ~bus.power;
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
